// File: rtl/stream_demux_1_n.sv
// Registered 1:N stream demultiplexer: each packet is routed whole to the channel
// picked on its head beat; heads with an out-of-range select are swallowed and counted.
module stream_demux_1_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    din,
  input  logic [SEL_W-1:0]    sel,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [WIDTH-1:0]    dout,
  output logic [CHANNELS-1:0] out_valid,
  output logic                out_last,
  input  logic [CHANNELS-1:0] out_ready,
  output logic                busy,
  output logic [15:0]         drop_cnt
);

  localparam logic [SEL_W:0]      LP_NCH = (SEL_W + 1)'(CHANNELS);
  localparam logic [CHANNELS-1:0] LP_ONE = CHANNELS'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_lock;
  logic [SEL_W-1:0]   r_chan_p1;
  logic [WIDTH-1:0]   r_data_p1;
  logic               r_last_p1;
  logic               r_vld_p1;
  logic [15:0]        r_drop_cnt;

  logic               w_sel_ok;
  logic               w_dst_rdy;
  logic               w_take;
  logic               w_can_load;
  logic               w_route;
  logic               w_drop;
  logic               w_acc;
  logic               w_load;
  logic               w_head_drop;
  logic               w_lock_ld;
  logic [SEL_W-1:0]   w_dest;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_sel_ok   = ({1'b0, sel} < LP_NCH);
  assign w_dst_rdy  = out_ready[r_chan_p1];
  assign w_take     = r_vld_p1 && w_dst_rdy;
  // The output register can reload in the same cycle it drains.
  assign w_can_load = !r_vld_p1 || w_dst_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_route     = 1'b0;
    w_drop      = 1'b0;
    w_dest      = r_lock;
    w_head_drop = 1'b0;
    w_lock_ld   = 1'b0;
    in_ready    = 1'b1;
    w_acc       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_sel_ok) begin
          w_route = 1'b1;
          w_dest  = sel;
        end else begin
          w_drop = 1'b1;
        end
      end
      ST_ROUTE: w_route = 1'b1;
      ST_DROP:  w_drop  = 1'b1;
      default:  w_state_nxt = ST_IDLE;
    endcase

    // Dropped beats never touch the output register, so they need no space there.
    in_ready = w_drop ? 1'b1 : w_can_load;
    w_acc    = in_valid && in_ready;

    if (w_acc) begin
      case (r_state)
        ST_IDLE: begin
          w_head_drop = !w_sel_ok;
          if (!in_last) begin
            if (w_sel_ok) begin
              w_state_nxt = ST_ROUTE;
              w_lock_ld   = 1'b1;
            end else begin
              w_state_nxt = ST_DROP;
            end
          end
        end
        ST_ROUTE, ST_DROP: begin
          if (in_last) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_load = w_acc && w_route;

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock     <= '0;
      r_chan_p1  <= '0;
      r_data_p1  <= '0;
      r_last_p1  <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_lock_ld) r_lock <= sel;
      if (w_load) begin
        r_data_p1 <= din;
        r_last_p1 <= in_last;
        r_chan_p1 <= w_dest;
        r_vld_p1  <= 1'b1;
      end else if (w_take) begin
        r_vld_p1 <= 1'b0;
      end
      if (w_head_drop) r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
  end

  assign out_valid = r_vld_p1 ? (LP_ONE << r_chan_p1) : '0;
  assign dout      = r_vld_p1 ? r_data_p1 : '0;
  assign out_last  = r_vld_p1 & r_last_p1;
  assign busy      = (r_state != ST_IDLE);
  assign drop_cnt  = r_drop_cnt;

endmodule
